uart_cmd_controller: RTL and testbench

//  Command sequencer between uart_rx/uart_tx (BaudClk domain, 256 clks/bit) and board outputs.

---
 rtl/uart_cmd_pkg.sv | 34 +++
 rtl/uart_cmd_regfile.sv | 69 ++++++
 rtl/uart_cmd_controller.sv | 207 ++++++++++++++++++++
 tb/tb_uart_cmd_controller.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared constants, register map and FSM encoding for the UART command controller.
package uart_cmd_pkg;

    localparam logic [7:0] SYNC   = 8'hA5;
    localparam logic [7:0] CMD_WR = 8'h01;
    localparam logic [7:0] CMD_RD = 8'h02;
    localparam logic [7:0] ACK    = 8'h06;
    localparam logic [7:0] NAK    = 8'h15;

    localparam logic [7:0] REG_LED    = 8'd0;
    localparam logic [7:0] REG_R      = 8'd1;
    localparam logic [7:0] REG_G      = 8'd2;
    localparam logic [7:0] REG_B      = 8'd3;
    localparam logic [7:0] REG_COMMIT = 8'd4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CMD     = 3'd1,
        ST_ADDR    = 3'd2,
        ST_DATA    = 3'd3,
        ST_CHK     = 3'd4,
        ST_EXEC    = 3'd5,
        ST_TX_LOAD = 3'd6,
        ST_TX_WAIT = 3'd7
    } state_e;

    // Frame checksum: XOR of the three payload bytes.
    function automatic logic [7:0] frame_chk(input logic [7:0] cmd,
                                             input logic [7:0] addr,
                                             input logic [7:0] data);
        return cmd ^ addr ^ data;
    endfunction

endpackage

// File: rtl/uart_cmd_regfile.sv
// Register file: LED, colour shadows, commit trigger and scratch registers.
// A write to the commit address copies the shadows to the colour output.
module uart_cmd_regfile
    import uart_cmd_pkg::*;
#(
    parameter int NUM_REGS = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic [7:0]  wr_addr,
    input  logic [7:0]  wr_data,
    input  logic [7:0]  rd_addr,
    output logic [7:0]  rd_data,
    output logic [4:0]  led,
    output logic [23:0] rgb,
    output logic        rgb_valid
);

    localparam int AW = $clog2(NUM_REGS);

    logic [7:0]  regs_r [NUM_REGS];
    logic [23:0] rgb_r;
    logic        rgb_valid_r;

    // Register storage; the commit address has no storage of its own.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= 8'h00;
            end
        end else if (wr_en && (wr_addr != REG_COMMIT)) begin
            regs_r[wr_addr[AW-1:0]] <= wr_data;
        end else begin
            regs_r <= regs_r;
        end
    end

    // Commit: latch {G,R,B} from the shadows and pulse valid for one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_r       <= 24'h000000;
            rgb_valid_r <= 1'b0;
        end else if (wr_en && (wr_addr == REG_COMMIT)) begin
            rgb_r       <= {regs_r[REG_G[AW-1:0]], regs_r[REG_R[AW-1:0]], regs_r[REG_B[AW-1:0]]};
            rgb_valid_r <= 1'b1;
        end else begin
            rgb_r       <= rgb_r;
            rgb_valid_r <= 1'b0;
        end
    end

    // Read mux: commit address and out-of-range addresses read as zero.
    always_comb begin
        rd_data = 8'h00;
        if (rd_addr == REG_COMMIT) begin
            rd_data = 8'h00;
        end else if (rd_addr < 8'(NUM_REGS)) begin
            rd_data = regs_r[rd_addr[AW-1:0]];
        end else begin
            rd_data = 8'h00;
        end
    end

    assign led       = regs_r[REG_LED[AW-1:0]][4:0];
    assign rgb       = rgb_r;
    assign rgb_valid = rgb_valid_r;

endmodule

// File: rtl/uart_cmd_controller.sv
// Host command sequencer: parses SYNC/CMD/ADDR/DATA/CHK frames from uart_rx,
// executes register reads/writes and returns ACK/NAK (+data) through uart_tx.
module uart_cmd_controller
    import uart_cmd_pkg::*;
#(
    parameter int TIMEOUT_CLKS = 65536,
    parameter int NUM_REGS     = 8
) (
    input  logic        i_Clock,
    input  logic        i_Resetn,
    input  logic        i_Rx_DV,
    input  logic [7:0]  i_Rx_Byte,
    output logic        o_Tx_DV,
    output logic [7:0]  o_Tx_Byte,
    input  logic        i_Tx_Active,
    input  logic        i_Tx_Done,
    output logic [4:0]  o_Led,
    output logic [23:0] o_Rgb,
    output logic        o_Rgb_Valid,
    output logic        o_Frame_Err,
    output logic        o_Overrun
);

    localparam int            TW      = $clog2(TIMEOUT_CLKS);
    localparam logic [TW-1:0] TO_TERM = TW'(TIMEOUT_CLKS - 1);

    state_e        state_r, next_state_s;
    logic [7:0]    cmd_r, addr_r, data_r, chk_r;
    logic [TW-1:0] to_cnt_r;
    logic          in_frame_s, rx_busy_s, to_hit_s;
    logic          chk_ok_s, cmd_ok_s, addr_ok_s, frame_ok_s;
    logic          wr_en_s;
    logic [7:0]    rd_data_s;
    logic [7:0]    reply_first_r, reply_data_r;
    logic          reply_two_r, tx_idx_r;
    logic          tx_dv_r, frame_err_r, overrun_r;
    logic [7:0]    tx_byte_r;
    logic          tx_dv_nxt_s, frame_err_nxt_s, overrun_nxt_s;
    logic [7:0]    tx_byte_nxt_s;

    // Frame status: where we are, whether the timeout fires, whether the frame is valid.
    always_comb begin
        in_frame_s = (state_r == ST_CMD) || (state_r == ST_ADDR) ||
                     (state_r == ST_DATA) || (state_r == ST_CHK);
        rx_busy_s  = (state_r == ST_EXEC) || (state_r == ST_TX_LOAD) ||
                     (state_r == ST_TX_WAIT);
        // A byte arriving on the terminal count wins over the timeout.
        to_hit_s   = in_frame_s && !i_Rx_DV && (to_cnt_r == TO_TERM);
        chk_ok_s   = (frame_chk(cmd_r, addr_r, data_r) == chk_r);
        cmd_ok_s   = (cmd_r == CMD_WR) || (cmd_r == CMD_RD);
        addr_ok_s  = (addr_r < 8'(NUM_REGS));
        frame_ok_s = chk_ok_s && cmd_ok_s && addr_ok_s;
        wr_en_s    = (state_r == ST_EXEC) && frame_ok_s && (cmd_r == CMD_WR);
    end

    uart_cmd_regfile #(
        .NUM_REGS (NUM_REGS)
    ) u_regfile (
        .clk       (i_Clock),
        .rst_n     (i_Resetn),
        .wr_en     (wr_en_s),
        .wr_addr   (addr_r),
        .wr_data   (data_r),
        .rd_addr   (addr_r),
        .rd_data   (rd_data_s),
        .led       (o_Led),
        .rgb       (o_Rgb),
        .rgb_valid (o_Rgb_Valid)
    );

    // FSM state register.
    always_ff @(posedge i_Clock or negedge i_Resetn) begin
        if (!i_Resetn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (i_Rx_DV && (i_Rx_Byte == SYNC)) next_state_s = ST_CMD;
                else                                next_state_s = ST_IDLE;
            end
            ST_CMD: begin
                if (i_Rx_DV)       next_state_s = ST_ADDR;
                else if (to_hit_s) next_state_s = ST_IDLE;
                else               next_state_s = ST_CMD;
            end
            ST_ADDR: begin
                if (i_Rx_DV)       next_state_s = ST_DATA;
                else if (to_hit_s) next_state_s = ST_IDLE;
                else               next_state_s = ST_ADDR;
            end
            ST_DATA: begin
                if (i_Rx_DV)       next_state_s = ST_CHK;
                else if (to_hit_s) next_state_s = ST_IDLE;
                else               next_state_s = ST_DATA;
            end
            ST_CHK: begin
                if (i_Rx_DV)       next_state_s = ST_EXEC;
                else if (to_hit_s) next_state_s = ST_IDLE;
                else               next_state_s = ST_CHK;
            end
            ST_EXEC: next_state_s = ST_TX_LOAD;
            ST_TX_LOAD: begin
                // tx_dv_r high means the strobe for this byte is on the wire now.
                if (tx_dv_r) next_state_s = ST_TX_WAIT;
                else         next_state_s = ST_TX_LOAD;
            end
            ST_TX_WAIT: begin
                if (i_Tx_Done && !tx_idx_r && reply_two_r) next_state_s = ST_TX_LOAD;
                else if (i_Tx_Done)                        next_state_s = ST_IDLE;
                else                                       next_state_s = ST_TX_WAIT;
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // FSM output logic: next values of the registered outputs.
    always_comb begin
        // The strobe is raised on the edge that enters TX_LOAD when uart_tx is idle,
        // otherwise on a later edge once it goes idle.
        tx_dv_nxt_s     = (next_state_s == ST_TX_LOAD) && !i_Tx_Active;
        tx_byte_nxt_s   = tx_byte_r;
        if (tx_dv_nxt_s) begin
            case (state_r)
                ST_EXEC:    tx_byte_nxt_s = frame_ok_s ? ACK : NAK;
                ST_TX_WAIT: tx_byte_nxt_s = reply_data_r;
                ST_TX_LOAD: tx_byte_nxt_s = tx_idx_r ? reply_data_r : reply_first_r;
                default:    tx_byte_nxt_s = tx_byte_r;
            endcase
        end else begin
            tx_byte_nxt_s = tx_byte_r;
        end
        frame_err_nxt_s = ((state_r == ST_EXEC) && !frame_ok_s) || to_hit_s;
        overrun_nxt_s   = i_Rx_DV && rx_busy_s;
    end

    // Registered outputs towards uart_tx and the status pulses.
    always_ff @(posedge i_Clock or negedge i_Resetn) begin
        if (!i_Resetn) begin
            tx_dv_r     <= 1'b0;
            tx_byte_r   <= 8'h00;
            frame_err_r <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            tx_dv_r     <= tx_dv_nxt_s;
            tx_byte_r   <= tx_byte_nxt_s;
            frame_err_r <= frame_err_nxt_s;
            overrun_r   <= overrun_nxt_s;
        end
    end

    // Frame byte capture, inter-byte timeout counter and reply bookkeeping.
    always_ff @(posedge i_Clock or negedge i_Resetn) begin
        if (!i_Resetn) begin
            cmd_r         <= 8'h00;
            addr_r        <= 8'h00;
            data_r        <= 8'h00;
            chk_r         <= 8'h00;
            to_cnt_r      <= '0;
            reply_first_r <= 8'h00;
            reply_data_r  <= 8'h00;
            reply_two_r   <= 1'b0;
            tx_idx_r      <= 1'b0;
        end else begin
            if (i_Rx_DV) begin
                case (state_r)
                    ST_CMD:  cmd_r  <= i_Rx_Byte;
                    ST_ADDR: addr_r <= i_Rx_Byte;
                    ST_DATA: data_r <= i_Rx_Byte;
                    ST_CHK:  chk_r  <= i_Rx_Byte;
                    default: cmd_r  <= cmd_r;
                endcase
            end else begin
                cmd_r <= cmd_r;
            end

            if (in_frame_s && !i_Rx_DV && !to_hit_s) begin
                to_cnt_r <= to_cnt_r + TW'(1);
            end else begin
                to_cnt_r <= '0;
            end

            if (state_r == ST_EXEC) begin
                reply_first_r <= frame_ok_s ? ACK : NAK;
                reply_data_r  <= rd_data_s;
                reply_two_r   <= frame_ok_s && (cmd_r == CMD_RD);
                tx_idx_r      <= 1'b0;
            end else if ((state_r == ST_TX_WAIT) && i_Tx_Done) begin
                tx_idx_r      <= 1'b1;
            end else begin
                tx_idx_r      <= tx_idx_r;
            end
        end
    end

    assign o_Tx_DV     = tx_dv_r;
    assign o_Tx_Byte   = tx_byte_r;
    assign o_Frame_Err = frame_err_r;
    assign o_Overrun   = overrun_r;

endmodule

// File: tb/tb_uart_cmd_controller.sv
// Self-checking bench for uart_cmd_controller: directed frame table, multi-cycle
// corner sequences (latency, commit, overrun, timeout, reset) and random frames
// checked against a register-level reference model.
module tb_uart_cmd_controller;

    localparam int TO_CLKS = 1024;
    localparam int TXB     = 16;   // uart_tx model busy cycles per byte
    localparam int SETTLE  = 60;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_Rx_DV;
    logic [7:0]  i_Rx_Byte;
    logic        o_Tx_DV;
    logic [7:0]  o_Tx_Byte;
    logic        i_Tx_Active;
    logic        i_Tx_Done;
    logic [4:0]  o_Led;
    logic [23:0] o_Rgb;
    logic        o_Rgb_Valid;
    logic        o_Frame_Err;
    logic        o_Overrun;

    uart_cmd_controller #(.TIMEOUT_CLKS(TO_CLKS), .NUM_REGS(8)) dut (
        .i_Clock     (clk),
        .i_Resetn    (rst_n),
        .i_Rx_DV     (i_Rx_DV),
        .i_Rx_Byte   (i_Rx_Byte),
        .o_Tx_DV     (o_Tx_DV),
        .o_Tx_Byte   (o_Tx_Byte),
        .i_Tx_Active (i_Tx_Active),
        .i_Tx_Done   (i_Tx_Done),
        .o_Led       (o_Led),
        .o_Rgb       (o_Rgb),
        .o_Rgb_Valid (o_Rgb_Valid),
        .o_Frame_Err (o_Frame_Err),
        .o_Overrun   (o_Overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- output monitor (samples on falling edge) ----------------
    logic [7:0] tx_q[$];
    int         tx_cyc_q[$];
    int         tx_dv_n = 0, done_n = 0, err_n = 0, ovr_n = 0, rgbv_n = 0;
    int         order_viol = 0, byte_viol = 0, err_cyc = 0;
    logic [7:0] last_tx_byte = 8'h00;

    always @(negedge clk) begin
        if (o_Tx_DV === 1'b1) begin
            tx_q.push_back(o_Tx_Byte);
            tx_cyc_q.push_back(cyc);
            if (tx_dv_n != done_n) order_viol <= order_viol + 1;
            tx_dv_n      <= tx_dv_n + 1;
            last_tx_byte <= o_Tx_Byte;
        end
        if (i_Tx_Active && (o_Tx_Byte !== last_tx_byte)) byte_viol <= byte_viol + 1;
        if (i_Tx_Done)   done_n <= done_n + 1;
        if (o_Frame_Err) begin err_n <= err_n + 1; err_cyc <= cyc; end
        if (o_Overrun)   ovr_n  <= ovr_n + 1;
        if (o_Rgb_Valid) rgbv_n <= rgbv_n + 1;
    end

    // ---------------- uart_tx behavioural model ----------------
    initial begin
        i_Tx_Active = 1'b0;
        i_Tx_Done   = 1'b0;
        forever begin
            @(negedge clk);
            if (o_Tx_DV === 1'b1) begin
                @(posedge clk); #1 i_Tx_Active = 1'b1;
                repeat (TXB) @(posedge clk);
                #1 i_Tx_Active = 1'b0; i_Tx_Done = 1'b1;
                @(posedge clk); #1 i_Tx_Done = 1'b0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    int last_rx_cyc = 0;

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        i_Rx_DV = 1'b1; i_Rx_Byte = b; last_rx_cyc = cyc;
        @(posedge clk); #1;
        i_Rx_DV = 1'b0;
    endtask

    task automatic send_frame(input logic [39:0] f, input int gap);
        logic [39:0] fr;
        fr = f;
        for (int j = 4; j >= 0; j--) begin
            send_byte(fr[j*8 +: 8]);
            repeat (gap) @(posedge clk);
        end
    endtask

    // Send a frame, let the reply finish, compare reply bytes, latency, error pulse and LEDs.
    task automatic run_frame(input string nm, input logic [39:0] f, input int n,
                             input logic [7:0] r0, input logic [7:0] r1, input int e,
                             input logic [4:0] led);
        int e0;
        tx_q.delete(); tx_cyc_q.delete();
        e0 = err_n;
        send_frame(f, 0);
        repeat (SETTLE) @(posedge clk);
        #1;
        chk({nm, " reply count"}, 64'(tx_q.size()), 64'(n));
        if (tx_q.size() > 0) begin
            chk({nm, " reply byte0"}, 64'(tx_q[0]), 64'(r0));
            chk({nm, " latency"}, 64'(tx_cyc_q[0] - last_rx_cyc), 64'd2);
        end
        if (n == 2 && tx_q.size() > 1) chk({nm, " reply byte1"}, 64'(tx_q[1]), 64'(r1));
        chk({nm, " frame_err pulses"}, 64'(err_n - e0), 64'(e));
        chk({nm, " led"}, 64'(o_Led), 64'(led));
    endtask

    // ---------------- reference model (register-map level) ----------------
    logic [7:0]  m_regs [8];
    logic [23:0] m_rgb;

    task automatic model_frame(input logic [7:0] c, input logic [7:0] a, input logic [7:0] d,
                               input logic [7:0] k, output int n, output logic [7:0] r0,
                               output logic [7:0] r1, output int e, output int rv);
        n = 1; r0 = 8'h15; r1 = 8'h00; e = 1; rv = 0;
        if (((c ^ a ^ d) == k) && (c == 8'h01 || c == 8'h02) && (a < 8'd8)) begin
            e = 0; r0 = 8'h06;
            if (c == 8'h01) begin
                if (a == 8'd4) begin
                    m_rgb = {m_regs[2], m_regs[1], m_regs[3]};
                    rv = 1;
                end else begin
                    m_regs[a[2:0]] = d;
                end
            end else begin
                n = 2;
                r1 = (a == 8'd4) ? 8'h00 : m_regs[a[2:0]];
            end
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct packed {
        logic [39:0] frame;
        logic [1:0]  n;
        logic [7:0]  r0;
        logic [7:0]  r1;
        logic        e;
        logic [4:0]  led;
    } vec_t;

    vec_t vecs [17];

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int e0, o0, v0, t0, n, e, rv;
        logic [7:0] r0, r1, c, a, d, k;

        vecs[0]  = '{40'hA5_01_00_15_14, 2'd1, 8'h06, 8'h00, 1'b0, 5'h15}; // LED write
        vecs[1]  = '{40'hA5_01_01_FF_FF, 2'd1, 8'h06, 8'h00, 1'b0, 5'h15}; // R=FF
        vecs[2]  = '{40'hA5_01_02_10_13, 2'd1, 8'h06, 8'h00, 1'b0, 5'h15}; // G=10
        vecs[3]  = '{40'hA5_01_03_01_03, 2'd1, 8'h06, 8'h00, 1'b0, 5'h15}; // B=01
        vecs[4]  = '{40'hA5_01_05_3C_38, 2'd1, 8'h06, 8'h00, 1'b0, 5'h15}; // reg5=3C
        vecs[5]  = '{40'hA5_02_05_00_07, 2'd2, 8'h06, 8'h3C, 1'b0, 5'h15}; // read reg5
        vecs[6]  = '{40'hA5_01_00_15_00, 2'd1, 8'h15, 8'h00, 1'b1, 5'h15}; // bad CHK
        vecs[7]  = '{40'hA5_01_09_01_08, 2'd1, 8'h15, 8'h00, 1'b1, 5'h15}; // bad ADDR (CHK also off)
        vecs[8]  = '{40'hA5_01_09_01_09, 2'd1, 8'h15, 8'h00, 1'b1, 5'h15}; // bad ADDR, good CHK
        vecs[9]  = '{40'hA5_07_00_00_07, 2'd1, 8'h15, 8'h00, 1'b1, 5'h15}; // bad CMD
        vecs[10] = '{40'hA5_02_00_00_02, 2'd2, 8'h06, 8'h15, 1'b0, 5'h15}; // read LED
        vecs[11] = '{40'hA5_02_04_00_06, 2'd2, 8'h06, 8'h00, 1'b0, 5'h15}; // commit reads 0
        vecs[12] = '{40'hA5_02_08_00_0A, 2'd1, 8'h15, 8'h00, 1'b1, 5'h15}; // read ADDR=NUM_REGS
        vecs[13] = '{40'hA5_02_01_00_03, 2'd2, 8'h06, 8'hFF, 1'b0, 5'h15}; // read R
        vecs[14] = '{40'hA5_01_00_FF_FE, 2'd1, 8'h06, 8'h00, 1'b0, 5'h1F}; // LED upper bits
        vecs[15] = '{40'hA5_02_00_00_02, 2'd2, 8'h06, 8'hFF, 1'b0, 5'h1F}; // full 8-bit reg0
        vecs[16] = '{40'hA5_01_00_0A_0B, 2'd1, 8'h06, 8'h00, 1'b0, 5'h0A};

        rst_n = 1'b0; i_Rx_DV = 1'b0; i_Rx_Byte = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset outputs", {o_Tx_DV, o_Tx_Byte, o_Led, o_Rgb, o_Rgb_Valid, o_Frame_Err, o_Overrun}, 64'd0);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Bytes other than SYNC in IDLE are ignored silently.
        e0 = err_n;
        send_byte(8'h00); send_byte(8'h5A); send_byte(8'h15);
        repeat (SETTLE) @(posedge clk);
        chk("idle junk no reply", 64'(tx_dv_n), 64'd0);
        chk("idle junk no error", 64'(err_n - e0), 64'd0);

        for (int i = 0; i < 17; i++) begin
            run_frame($sformatf("vec%0d", i), vecs[i].frame, int'(vecs[i].n), vecs[i].r0,
                      vecs[i].r1, int'(vecs[i].e), vecs[i].led);
        end
        chk("rgb unchanged before commit", 64'(o_Rgb), 64'd0);
        chk("no rgb_valid before commit", 64'(rgbv_n), 64'd0);

        // Commit the colour shadows.
        run_frame("commit", 40'hA5_01_04_00_05, 1, 8'h06, 8'h00, 0, 5'h0A);
        chk("commit rgb", 64'(o_Rgb), 64'h10FF01);
        chk("commit rgb_valid pulses", 64'(rgbv_n), 64'd1);

        // Overrun: a byte injected while the reply is in flight is dropped.
        tx_q.delete(); tx_cyc_q.delete();
        e0 = err_n; o0 = ovr_n; v0 = tx_dv_n;
        send_frame(40'hA5_02_05_00_07, 0);
        for (int i = 0; i < 50 && tx_dv_n == v0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        send_byte(8'hA5);
        repeat (SETTLE) @(posedge clk);
        #1;
        chk("overrun pulses", 64'(ovr_n - o0), 64'd1);
        chk("overrun reply count", 64'(tx_q.size()), 64'd2);
        if (tx_q.size() == 2) begin
            chk("overrun reply byte0", 64'(tx_q[0]), 64'h06);
            chk("overrun reply byte1", 64'(tx_q[1]), 64'h3C);
        end
        chk("overrun no frame_err", 64'(err_n - e0), 64'd0);

        // Timeout after three bytes: error TO_CLKS+1 cycles after the last byte, no reply.
        // The counter is 0 in the first idle cycle and hits TO_CLKS-1 in idle cycle TO_CLKS;
        // the pulse is registered in the following cycle.
        tx_q.delete(); tx_cyc_q.delete();
        e0 = err_n;
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
        t0 = last_rx_cyc;
        for (int i = 0; i < TO_CLKS + 20 && err_n == e0; i++) @(posedge clk);
        repeat (5) @(posedge clk);
        #1;
        chk("timeout frame_err pulses", 64'(err_n - e0), 64'd1);
        chk("timeout pulse cycle", 64'(err_cyc - t0), 64'(TO_CLKS + 1));
        chk("timeout no reply", 64'(tx_q.size()), 64'd0);
        run_frame("after timeout write", 40'hA5_01_06_77_70, 1, 8'h06, 8'h00, 0, 5'h0A);
        run_frame("after timeout read", 40'hA5_02_06_00_04, 2, 8'h06, 8'h77, 0, 5'h0A);

        // Byte on the terminal count cycle wins: frame continues, no error.
        tx_q.delete(); tx_cyc_q.delete();
        e0 = err_n;
        send_byte(8'hA5); send_byte(8'h01);
        t0 = last_rx_cyc;
        while (cyc < t0 + TO_CLKS - 1) begin @(posedge clk); #1; end
        send_byte(8'h07);
        chk("terminal byte cycle", 64'(last_rx_cyc - t0), 64'(TO_CLKS));
        send_byte(8'h55); send_byte(8'h53);
        repeat (SETTLE) @(posedge clk);
        #1;
        chk("terminal byte no error", 64'(err_n - e0), 64'd0);
        chk("terminal byte reply", 64'(tx_q.size() > 0 ? tx_q[0] : 8'hEE), 64'h06);
        run_frame("terminal byte readback", 40'hA5_02_07_00_05, 2, 8'h06, 8'h55, 0, 5'h0A);

        // Reset mid-frame: everything returns to zero; next frame is accepted.
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
        rst_n = 1'b0;
        #2;
        chk("midframe reset outputs", {o_Tx_DV, o_Tx_Byte, o_Led, o_Rgb, o_Rgb_Valid, o_Frame_Err, o_Overrun}, 64'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        run_frame("after reset read", 40'hA5_02_05_00_07, 2, 8'h06, 8'h00, 0, 5'h00);

        // Random frames against the reference model.
        for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
        m_rgb = 24'h000000;
        for (int it = 0; it < 200; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                d = 8'($urandom);
                if (d == 8'hA5) d = 8'h00;
                send_byte(d);
            end
            case ($urandom_range(0, 9))
                0, 1, 2, 3: c = 8'h01;
                4, 5, 6, 7: c = 8'h02;
                default:    c = 8'($urandom);
            endcase
            a = 8'($urandom_range(0, 9));
            d = 8'($urandom);
            k = c ^ a ^ d;
            if ($urandom_range(0, 99) < 15) k = k ^ 8'($urandom_range(1, 255));
            model_frame(c, a, d, k, n, r0, r1, e, rv);
            tx_q.delete(); tx_cyc_q.delete();
            e0 = err_n; v0 = rgbv_n;
            send_frame({8'hA5, c, a, d, k}, $urandom_range(0, 2));
            repeat (SETTLE) @(posedge clk);
            #1;
            chk($sformatf("rand%0d reply count", it), 64'(tx_q.size()), 64'(n));
            if (tx_q.size() > 0) chk($sformatf("rand%0d byte0", it), 64'(tx_q[0]), 64'(r0));
            if (n == 2 && tx_q.size() > 1) chk($sformatf("rand%0d byte1", it), 64'(tx_q[1]), 64'(r1));
            chk($sformatf("rand%0d frame_err", it), 64'(err_n - e0), 64'(e));
            chk($sformatf("rand%0d rgb_valid", it), 64'(rgbv_n - v0), 64'(rv));
            chk($sformatf("rand%0d led", it), 64'(o_Led), 64'(m_regs[0][4:0]));
            chk($sformatf("rand%0d rgb", it), 64'(o_Rgb), 64'(m_rgb));
        end

        chk("tx strobe only after previous done", 64'(order_viol), 64'd0);
        chk("tx byte stable while active", 64'(byte_viol), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
